// File: rtl/interface_de_saida.sv
// Output interface: converts the counter value to two 7-segment digits through a
// double-dabble FSM and drives a PWM LED whose duty cycle tracks the displayed value.
module interface_de_saida (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] valor,
    input  logic       pulso,
    output logic [6:0] display_ls,
    output logic [6:0] display_ms,
    output logic       led,
    output logic       ocupado
);

    localparam int unsigned VALOR_W = 7;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned SR_W    = BCD_W + VALOR_W;
    localparam int unsigned ITER_W  = 3;

    localparam logic [VALOR_W-1:0] VALOR_MAX   = VALOR_W'(99);
    localparam logic [ITER_W-1:0]  ULTIMA_ITER = ITER_W'(6);
    localparam logic [6:0]         SEG_BLANK   = 7'b1111111;
    localparam logic [6:0]         SEG_ZERO    = 7'b1000000;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    estado_t              estado;
    logic [VALOR_W-1:0]   valor_atual;
    logic [VALOR_W-1:0]   valor_clamp;
    logic [SR_W-1:0]      sr;
    logic [SR_W-1:0]      sr_adj;
    logic [SR_W-1:0]      sr_next;
    logic [ITER_W-1:0]    iter;
    logic [VALOR_W-1:0]   duty_pendente;
    logic [VALOR_W-1:0]   duty_ativo;
    logic [VALOR_W-1:0]   contador_pwm;
    logic [6:0]           seg_ls;
    logic [6:0]           seg_ms;

    // Active-low gfedcba encoding of one BCD digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        valor_clamp = (valor > VALOR_MAX) ? VALOR_MAX : valor;
    end

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left
    always_comb begin
        sr_adj = sr;
        if (sr[10:7] >= 4'd5) begin
            sr_adj[10:7] = sr[10:7] + 4'd3;
        end
        if (sr[14:11] >= 4'd5) begin
            sr_adj[14:11] = sr[14:11] + 4'd3;
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};
    end

    always_comb begin
        seg_ls = seg7(sr[10:7]);
        seg_ms = (sr[14:11] == 4'd0) ? SEG_BLANK : seg7(sr[14:11]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            ocupado       <= 1'b0;
            valor_atual   <= '0;
            sr            <= '0;
            iter          <= '0;
            duty_pendente <= '0;
            duty_ativo    <= '0;
            contador_pwm  <= '0;
            led           <= 1'b0;
            display_ls    <= SEG_ZERO;
            display_ms    <= SEG_BLANK;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (valor_clamp != valor_atual) begin
                        valor_atual <= valor_clamp;
                        sr          <= {BCD_W'(0), valor_clamp};
                        iter        <= '0;
                        estado      <= CONVERTE;
                        ocupado     <= 1'b1;
                    end
                end
                CONVERTE: begin
                    sr   <= sr_next;
                    iter <= iter + ITER_W'(1);
                    if (iter == ULTIMA_ITER) begin
                        estado <= ATUALIZA;
                    end
                end
                ATUALIZA: begin
                    display_ls    <= seg_ls;
                    display_ms    <= seg_ms;
                    duty_pendente <= valor_atual;
                    estado        <= OCIOSO;
                    ocupado       <= 1'b0;
                end
                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase

            // Duty only changes at the period boundary so no period is truncated
            if (pulso) begin
                if (contador_pwm == VALOR_MAX) begin
                    contador_pwm <= '0;
                    duty_ativo   <= duty_pendente;
                end else begin
                    contador_pwm <= contador_pwm + VALOR_W'(1);
                end
            end

            led <= (contador_pwm < duty_ativo);
        end
    end

endmodule

// File: tb/tb_interface_de_saida.sv
// Directed bench for interface_de_saida: display conversion timing, clamping,
// mid-conversion changes, reset abort and PWM duty behaviour.
module tb_interface_de_saida;

    logic       clock;
    logic       reset;
    logic [6:0] valor;
    logic       pulso;
    logic [6:0] display_ls;
    logic [6:0] display_ms;
    logic       led;
    logic       ocupado;

    int vectors;
    int errors;

    interface_de_saida dut (
        .clock      (clock),
        .reset      (reset),
        .valor      (valor),
        .pulso      (pulso),
        .display_ls (display_ls),
        .display_ms (display_ms),
        .led        (led),
        .ocupado    (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        valor = 7'd0;
        pulso = 1'b0;
        apply_reset();
        vectors++;
        if (display_ls !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ls: got %b expected %b", display_ls, 7'b1000000);
        end
        vectors++;
        if (display_ms !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_ms: got %b expected %b", display_ms, 7'b1111111);
        end
        vectors++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL reset_led: got %b expected 0", led);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (ocupado !== 1'b0) begin
                errors++;
                $display("FAIL idle_ocupado cycle %0d: got %b expected 0", i, ocupado);
            end
        end
        vectors++;
        if (display_ms !== 7'b1111111 || display_ls !== 7'b1000000) begin
            errors++;
            $display("FAIL idle_display: got ms=%b ls=%b expected ms=1111111 ls=1000000",
                     display_ms, display_ls);
        end
    endtask

    task automatic test_conversion_47();
        valor = 7'd47;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (ocupado !== 1'b1) begin
                errors++;
                $display("FAIL conv47_ocupado C+%0d: got %b expected 1", i, ocupado);
            end
            vectors++;
            if (display_ls !== 7'b1000000) begin
                errors++;
                $display("FAIL conv47_early_ls C+%0d: got %b expected 1000000", i, display_ls);
            end
        end
        tick();
        vectors++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL conv47_done_ocupado: got %b expected 0", ocupado);
        end
        vectors++;
        if (display_ms !== 7'b0011001) begin
            errors++;
            $display("FAIL conv47_ms: got %b expected 0011001", display_ms);
        end
        vectors++;
        if (display_ls !== 7'b1111000) begin
            errors++;
            $display("FAIL conv47_ls: got %b expected 1111000", display_ls);
        end
    endtask

    task automatic test_clamp();
        valor = 7'd120;
        tick();
        vectors++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL clamp_start: got %b expected 1", ocupado);
        end
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (display_ms !== 7'b0010000 || display_ls !== 7'b0010000) begin
            errors++;
            $display("FAIL clamp_99: got ms=%b ls=%b expected 0010000 0010000",
                     display_ms, display_ls);
        end
        // Clamped value equals the stored one, so no new conversion
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (ocupado !== 1'b0) begin
                errors++;
                $display("FAIL clamp_stable %0d: got %b expected 0", i, ocupado);
            end
        end
    endtask

    task automatic test_mid_change();
        valor = 7'd30;
        tick();
        tick();
        tick();
        valor = 7'd60;
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (display_ms !== 7'b0110000 || display_ls !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_first30: got ms=%b ls=%b expected 0110000 1000000",
                     display_ms, display_ls);
        end
        vectors++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: got %b expected 0", ocupado);
        end
        tick();
        vectors++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL mid_second_start: got %b expected 1", ocupado);
        end
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (display_ms !== 7'b0000010 || display_ls !== 7'b1000000 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL mid_final60: got ms=%b ls=%b oc=%b expected 0000010 1000000 0",
                     display_ms, display_ls, ocupado);
        end
    endtask

    task automatic test_reset_mid();
        valor = 7'd77;
        tick();
        vectors++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_start: got %b expected 1", ocupado);
        end
        tick();
        tick();
        tick();
        reset = 1'b1;
        valor = 7'd0;
        tick();
        reset = 1'b0;
        vectors++;
        if (ocupado !== 1'b0 || dut.estado !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_state: got oc=%b estado=%0d expected 0 0", ocupado, dut.estado);
        end
        vectors++;
        if (display_ms !== 7'b1111111 || display_ls !== 7'b1000000 || led !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ms=%b ls=%b led=%b expected 1111111 1000000 0",
                     display_ms, display_ls, led);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (ocupado !== 1'b0 || display_ls !== 7'b1000000) begin
                errors++;
                $display("FAIL rstmid_after %0d: got oc=%b ls=%b expected 0 1000000",
                         i, ocupado, display_ls);
            end
        end
    endtask

    task automatic test_pwm();
        int highs;
        valor = 7'd25;
        pulso = 1'b0;
        apply_reset();
        for (int i = 0; i < 9; i++) tick();
        vectors++;
        if (display_ms !== 7'b0100100 || display_ls !== 7'b0010010) begin
            errors++;
            $display("FAIL pwm_disp25: got ms=%b ls=%b expected 0100100 0010010",
                     display_ms, display_ls);
        end
        pulso = 1'b1;
        // First period still runs with the reset duty of 0
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (led === 1'b1) highs++;
        end
        vectors++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL pwm_period0: got %0d high ticks expected 0", highs);
        end
        for (int p = 1; p <= 3; p++) begin
            highs = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (led === 1'b1) highs++;
                if (p == 1 && i == 0) begin
                    vectors++;
                    if (led !== 1'b1) begin
                        errors++;
                        $display("FAIL pwm_first_high: got %b expected 1", led);
                    end
                end
                if (p == 3 && i == 9) valor = 7'd50;
            end
            vectors++;
            if (highs !== 25) begin
                errors++;
                $display("FAIL pwm_period%0d: got %0d high ticks expected 25", p, highs);
            end
        end
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (led === 1'b1) highs++;
        end
        vectors++;
        if (highs !== 50) begin
            errors++;
            $display("FAIL pwm_period4: got %0d high ticks expected 50", highs);
        end
    endtask

    task automatic test_pulso_hold();
        for (int i = 0; i < 10; i++) tick();
        pulso = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            vectors++;
            if (dut.contador_pwm !== 7'd10 || led !== 1'b1) begin
                errors++;
                $display("FAIL hold %0d: got cnt=%0d led=%b expected 10 1",
                         i, dut.contador_pwm, led);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        valor   = 7'd0;
        pulso   = 1'b0;
        test_reset();
        test_conversion_47();
        test_clamp();
        test_mid_change();
        test_reset_mid();
        test_pwm();
        test_pulso_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
